// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stall vectors, FSM states
// and the register address that ID treats as a NOP target.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam logic [4:0] NOP_REG_ADDR = 5'd0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between an EX-stage load and the
// two ID read ports; writes to the NOP register never create a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_is_load_i,
    input  logic [4:0] ex_waddr_i,
    input  logic       id_re1_i,
    input  logic [4:0] id_raddr1_i,
    input  logic       id_re2_i,
    input  logic [4:0] id_raddr2_i,
    output logic       hazard_o
);

    logic port1_hit;
    logic port2_hit;

    always_comb begin
        port1_hit = id_re1_i && (id_raddr1_i == ex_waddr_i);
        port2_hit = id_re2_i && (id_raddr2_i == ex_waddr_i);
        hazard_o  = ex_is_load_i && (ex_waddr_i != NOP_REG_ADDR) && (port1_hit || port2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges ID/EX stall sources into a hold vector, squashes
// IF/ID on taken branches, sequences multi-cycle EX ops, counts stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = 32,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stallreq_i,
    input  logic             id_be_i,
    input  logic             id_re1_i,
    input  logic             id_re2_i,
    input  logic [4:0]       id_raddr1_i,
    input  logic [4:0]       id_raddr2_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_waddr_i,
    input  logic             ex_mc_start_i,
    input  logic             mc_abort_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             mc_busy_o,
    output logic             mc_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int MC_CNT_W = $clog2(MC_CYCLES) + 1;
    localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_CYCLES - 1);
    localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(1);

    mc_state_t             state;
    logic [MC_CNT_W-1:0]   cnt;
    logic                  load_use;

    load_use_detect u_load_use_detect (
        .ex_is_load_i (ex_is_load_i),
        .ex_waddr_i   (ex_waddr_i),
        .id_re1_i     (id_re1_i),
        .id_raddr1_i  (id_raddr1_i),
        .id_re2_i     (id_re2_i),
        .id_raddr2_i  (id_raddr2_i),
        .hazard_o     (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_mc_start_i) begin
                        state <= MC_BUSY;
                        cnt   <= MC_LOAD;
                    end
                end
                MC_BUSY: begin
                    if (mc_abort_i) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == MC_LAST) begin
                            state <= MC_DONE;
                        end
                    end
                end
                MC_DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs are Mealy on state plus inputs; all forced low while rst is high.
    always_comb begin
        stall_o   = STALL_NONE;
        mc_busy_o = 1'b0;
        mc_done_o = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (ex_mc_start_i) begin
                        stall_o = STALL_EX;
                    end else if (load_use) begin
                        stall_o = STALL_ID;
                    end
                end
                MC_BUSY: begin
                    mc_busy_o = 1'b1;
                    if (!mc_abort_i) begin
                        stall_o = STALL_EX;
                    end
                end
                MC_DONE: begin
                    mc_done_o = 1'b1;
                end
                default: begin
                    stall_o = STALL_NONE;
                end
            endcase
        end
        flush_o = !rst && id_stallreq_i && id_be_i && !stall_o[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if ((stall_o != STALL_NONE) && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed checks of pipe_ctrl against a cycle-level reference
// model, on two instances (MC_CYCLES=4/CNT_W=4 and MC_CYCLES=8/CNT_W=32).
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic id_stallreq, id_be, re1, re2, ex_is_load, start, abort;
    logic [4:0] ra1, ra2, ex_waddr;

    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b, busy_a, busy_b, done_a, done_b;
    logic [3:0]  cnt_a;
    logic [31:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: remaining EX-occupancy cycles, pending done pulse, stall count.
    int     left  [2] = '{0, 0};
    bit     dpend [2] = '{0, 0};
    longint mcnt  [2] = '{0, 0};
    int     mcv   [2] = '{4, 8};
    longint cmax  [2] = '{64'd15, 64'hFFFF_FFFF};

    always #5 clk = ~clk;

    pipe_ctrl #(.MC_CYCLES(4), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .id_stallreq_i(id_stallreq), .id_be_i(id_be),
        .id_re1_i(re1), .id_re2_i(re2), .id_raddr1_i(ra1), .id_raddr2_i(ra2),
        .ex_is_load_i(ex_is_load), .ex_waddr_i(ex_waddr), .ex_mc_start_i(start),
        .mc_abort_i(abort), .stall_o(stall_a), .flush_o(flush_a),
        .mc_busy_o(busy_a), .mc_done_o(done_a), .stall_cnt_o(cnt_a)
    );

    pipe_ctrl #(.MC_CYCLES(8), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .id_stallreq_i(id_stallreq), .id_be_i(id_be),
        .id_re1_i(re1), .id_re2_i(re2), .id_raddr1_i(ra1), .id_raddr2_i(ra2),
        .ex_is_load_i(ex_is_load), .ex_waddr_i(ex_waddr), .ex_mc_start_i(start),
        .mc_abort_i(abort), .stall_o(stall_b), .flush_o(flush_b),
        .mc_busy_o(busy_b), .mc_done_o(done_b), .stall_cnt_o(cnt_b)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; id_stallreq = 1'b0; id_be = 1'b0; re1 = 1'b0; re2 = 1'b0;
        ra1 = '0; ra2 = '0; ex_is_load = 1'b0; ex_waddr = '0; start = 1'b0; abort = 1'b0;
    endtask

    // Called with inputs driven at a negedge; returns at the following negedge.
    task automatic step();
        int nl [2];
        bit nd [2];
        longint nc [2];
        logic [5:0] es;
        bit eb, ed, ef, lu;
        #1;
        lu = ex_is_load && (ex_waddr != 5'd0) &&
             ((re1 && ra1 == ex_waddr) || (re2 && ra2 == ex_waddr));
        for (int k = 0; k < 2; k++) begin
            es = 6'b0; eb = 0; ed = 0;
            nl[k] = left[k]; nd[k] = 0; nc[k] = mcnt[k];
            if (rst) begin
                nl[k] = 0; nc[k] = 0;
            end else begin
                if (dpend[k]) begin
                    ed = 1;
                end else if (left[k] > 0) begin
                    eb = 1;
                    if (abort) begin
                        nl[k] = 0;
                    end else begin
                        es = 6'b001111;
                        nl[k] = left[k] - 1;
                        nd[k] = (nl[k] == 0);
                    end
                end else if (start) begin
                    es = 6'b001111;
                    nl[k] = mcv[k] - 1;
                end else if (lu) begin
                    es = 6'b000111;
                end
                if (es != 6'b0 && mcnt[k] < cmax[k]) nc[k] = mcnt[k] + 1;
            end
            ef = !rst && id_stallreq && id_be && !es[1];
            check(k == 0 ? "A.stall" : "B.stall", k == 0 ? stall_a : stall_b, es);
            check(k == 0 ? "A.flush" : "B.flush", k == 0 ? flush_a : flush_b, ef);
            check(k == 0 ? "A.busy"  : "B.busy",  k == 0 ? busy_a  : busy_b,  eb);
            check(k == 0 ? "A.done"  : "B.done",  k == 0 ? done_a  : done_b,  ed);
            check(k == 0 ? "A.cnt"   : "B.cnt",   k == 0 ? longint'(cnt_a) : longint'(cnt_b), mcnt[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            left[k] = nl[k]; dpend[k] = nd[k]; mcnt[k] = nc[k];
        end
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd8;
            default: return 5'd31;
        endcase
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset held 3 cycles with start and a taken branch asserted.
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1; start = 1'b1; id_stallreq = 1'b1; id_be = 1'b1;
            step();
        end
        clear_inputs();
        step();
        check("rst_release_cnt", cnt_a, 0);

        // Multi-cycle op t0..t4.
        start = 1'b1;
        for (int i = 0; i < 4; i++) step();
        start = 1'b0;
        step();
        check("mc_cnt_t5", cnt_a, 4);
        for (int i = 0; i < 6; i++) step();

        // Load-use, then the same with the NOP destination.
        ex_is_load = 1'b1; ex_waddr = 5'd8; re2 = 1'b1; ra2 = 5'd8;
        step();
        clear_inputs();
        step();
        ex_is_load = 1'b1; ex_waddr = 5'd0; re2 = 1'b1; ra2 = 5'd0;
        step();
        clear_inputs();
        step();

        // Taken branch held in ID during an MC stall, then not-taken.
        start = 1'b1; id_stallreq = 1'b1; id_be = 1'b1;
        for (int i = 0; i < 4; i++) step();
        start = 1'b0;
        step();
        id_stallreq = 1'b0; id_be = 1'b0;
        for (int i = 0; i < 6; i++) step();
        id_stallreq = 1'b1; id_be = 1'b0;
        for (int i = 0; i < 3; i++) step();
        clear_inputs();
        step();

        // Abort at t2, new start at t3.
        start = 1'b1;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Continuous MC ops drive the 4-bit counter into saturation.
        rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b1;
        for (int i = 0; i < 25; i++) step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("sat_cnt", cnt_a, 15);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 63) == 0);
            start       = ($urandom_range(0, 3) == 0);
            abort       = ($urandom_range(0, 11) == 0);
            id_stallreq = ($urandom_range(0, 2) == 0);
            id_be       = $urandom_range(0, 1);
            ex_is_load  = $urandom_range(0, 1);
            ex_waddr    = pick_addr();
            re1         = $urandom_range(0, 1);
            re2         = $urandom_range(0, 1);
            ra1         = pick_addr();
            ra2         = pick_addr();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
